io_port: RTL and testbench
==========================

Name: io_port

Overview:
- Byte-wide I/O peripheral at the CPU's output/input data port; replaces the raw cpuin/cpuout wires.
- Captures CPU output writes into a TX FIFO and presents them to the outside world over a valid/ready handshake.
- Accepts external bytes over a valid/ready handshake into an RX FIFO, from which the CPU reads.
- Sticky error flags report dropped writes and empty reads.

Parameters:
- DEPTH, 4, entries per FIFO (TX and RX); power of two, >= 2
- WIDTH, 8, data width in bits

Ports:
- clock  in  1  single system clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- cpu_wr  in  1  one-cycle CPU write strobe; pushes cpu_wdata into TX FIFO
- cpu_wdata  in  WIDTH  byte written by CPU (output instruction)
- cpu_rd  in  1  one-cycle CPU read strobe; pops RX FIFO head
- cpu_rdata  out  WIDTH  RX FIFO head (first-word fall-through); 0 when RX empty
- tx_full  out  1  TX FIFO holds DEPTH entries
- rx_avail  out  1  RX FIFO non-empty
- out_valid  out  1  TX FIFO head valid toward external sink
- out_ready  in  1  external sink accepts out_data
- out_data  out  WIDTH  TX FIFO head; 0 when out_valid low
- in_valid  in  1  external source presents in_data
- in_ready  out  1  RX FIFO not full
- in_data  in  WIDTH  external input byte
- err_clear  in  1  clears both sticky error flags
- tx_overflow  out  1  sticky: cpu_wr while tx_full
- rx_underflow  out  1  sticky: cpu_rd while RX empty

Behaviour:
- Reset (synchronous, active-high): both FIFOs emptied, pointers and counts 0, error flags 0. Outputs after reset: tx_full=0, rx_avail=0, out_valid=0, out_data=0, in_ready=1, cpu_rdata=0. Reset asserted mid-transfer discards all buffered data; no handshake completes in a reset cycle.
- Each FIFO: circular buffer; read/write pointers $clog2(DEPTH) bits wrapping DEPTH-1 -> 0; count $clog2(DEPTH)+1 bits, range 0..DEPTH.
- Full/empty flags derive from the registered count at the start of the cycle.
- TX push: cpu_wr && !tx_full. cpu_wr && tx_full drops the byte and sets tx_overflow. This applies even when a pop occurs in the same cycle.
- TX pop: out_valid && out_ready. out_valid = TX count != 0. out_data holds stable until accepted.
- Latency: cpu_wr in cycle N into an empty TX FIFO gives out_valid=1 with that byte in cycle N+1.
- RX push: in_valid && in_ready. in_valid while !in_ready leaves the source stalled; no data is lost and no flag is set.
- RX pop: cpu_rd && rx_avail. cpu_rd on empty RX sets rx_underflow; pointers are unchanged.
- Latency: an RX handshake in cycle N gives rx_avail=1 and cpu_rdata=byte in cycle N+1.
- Simultaneous push and pop on a non-empty, non-full FIFO: count unchanged, both pointers advance.
- On an empty FIFO, pop is ignored and push lands.
- err_clear has priority over setting in the same cycle: flags become 0.
- FIFO ordering is strict; no reordering or duplication.

Optional Feature:
- Macro: IO_PORT_LOOPBACK_EN.
- Defined: adds input port loopback (1 bit). When loopback=1:
  - out_valid and in_ready are forced to 0.
  - TX head moves into RX, one byte per cycle, whenever TX is non-empty and RX is not full.
  - External handshakes are ignored.
  - Toggling loopback takes effect the same cycle and leaves buffered data intact.
- Undefined: the port is absent and behaviour is as above.

Decomposition:
- Package io_pkg: default WIDTH/DEPTH constants and a typedef for the byte type.
- Sub-module io_fifo (parameters DEPTH, WIDTH): push, pop, wdata, rdata, full, empty. Instantiated twice (TX, RX).
- io_port contains the handshake glue, error flags and loopback mux.

Test Plan:
- Reset, then cpu_wr 0xA5 with out_ready=1 -> out_valid=1, out_data=0xA5 next cycle; popped the cycle after; out_valid=0.
- out_ready=0; write 0x01..0x04 (DEPTH=4) -> tx_full=1. 5th write 0x05 -> tx_overflow=1. Drain -> 0x01,0x02,0x03,0x04 in order; 0x05 never appears.
- in_valid with 0x3C, 0x7E -> rx_avail=1, cpu_rdata=0x3C. cpu_rd -> 0x7E. cpu_rd -> rx_avail=0, cpu_rdata=0. Extra cpu_rd -> rx_underflow=1. err_clear -> 0.
- Hold in_valid for 6 bytes with no cpu_rd -> in_ready=0 after 4 accepted; bytes 5-6 held by source. Then cpu_rd each cycle -> all 6 bytes read in order, with pointer wrap verified.
- TX holds 2 entries, cpu_wr 0x55 and out_ready=1 in the same cycle -> count stays 2, order preserved. Reset asserted mid-stream -> all flags 0, out_valid=0 next cycle.
- With IO_PORT_LOOPBACK_EN and loopback=1: cpu_wr 0x11, 0x22 -> out_valid stays 0; rx_avail rises; cpu_rdata reads 0x11 then 0x22.

Source files
------------

// File: rtl/io_pkg.sv
// Shared constants and the byte type for the io_port block.
// Defaults match the CPU's byte-wide data port.
package io_pkg;

    localparam int IO_WIDTH = 8;
    localparam int IO_DEPTH = 4;

    typedef logic [IO_WIDTH-1:0] byte_t;

endpackage

// File: rtl/io_port_if.sv
// CPU-side and external-side signals of io_port, bundled for port connection.
// The slave modport is the peripheral's view; the master modport is the CPU/outside world's view.
interface io_port_if #(
    parameter int WIDTH = io_pkg::IO_WIDTH
);

    logic             cpu_wr;
    logic [WIDTH-1:0] cpu_wdata;
    logic             cpu_rd;
    logic [WIDTH-1:0] cpu_rdata;
    logic             tx_full;
    logic             rx_avail;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             err_clear;
    logic             tx_overflow;
    logic             rx_underflow;

    modport slave (
        input  cpu_wr, cpu_wdata, cpu_rd, out_ready, in_valid, in_data, err_clear,
        output cpu_rdata, tx_full, rx_avail, out_valid, out_data, in_ready,
               tx_overflow, rx_underflow
    );

    modport master (
        output cpu_wr, cpu_wdata, cpu_rd, out_ready, in_valid, in_data, err_clear,
        input  cpu_rdata, tx_full, rx_avail, out_valid, out_data, in_ready,
               tx_overflow, rx_underflow
    );

endinterface

// File: rtl/io_fifo.sv
// Circular-buffer FIFO with first-word fall-through read data (0 while empty).
// Push is ignored when full, pop is ignored when empty; flags come from the registered count.
module io_fifo
    import io_pkg::*;
#(
    parameter int DEPTH = IO_DEPTH,
    parameter int WIDTH = IO_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/io_port.sv
// Byte I/O peripheral: CPU writes -> TX FIFO -> valid/ready out; valid/ready in -> RX FIFO -> CPU reads.
// One cycle from write/handshake to visibility. Full TX drops writes (sticky tx_overflow); full RX stalls the source.
// Optional IO_PORT_LOOPBACK_EN adds a loopback input that routes TX straight into RX.
module io_port
    import io_pkg::*;
#(
    parameter int DEPTH = IO_DEPTH,
    parameter int WIDTH = IO_WIDTH
) (
    input  logic clock,
    input  logic reset,
`ifdef IO_PORT_LOOPBACK_EN
    input  logic loopback,
`endif
    io_port_if.slave bus
);

    logic             lb_en;
    logic             lb_move;
    logic             tx_push, tx_pop, tx_full_i, tx_empty;
    logic             rx_push, rx_pop, rx_full, rx_empty;
    logic [WIDTH-1:0] tx_head, rx_head, rx_wdata;
    logic             out_valid_i;
    logic             tx_overflow_q, tx_overflow_d;
    logic             rx_underflow_q, rx_underflow_d;

`ifdef IO_PORT_LOOPBACK_EN
    assign lb_en = loopback;
`else
    assign lb_en = 1'b0;
`endif

    always_comb begin
        lb_move  = lb_en && !tx_empty && !rx_full;
        tx_push  = bus.cpu_wr && !tx_full_i;
        tx_pop   = lb_en ? lb_move : (!tx_empty && bus.out_ready);
        rx_push  = lb_en ? lb_move : (bus.in_valid && !rx_full);
        rx_pop   = bus.cpu_rd && !rx_empty;
        rx_wdata = lb_en ? tx_head : bus.in_data;

        tx_overflow_d  = tx_overflow_q | (bus.cpu_wr && tx_full_i);
        rx_underflow_d = rx_underflow_q | (bus.cpu_rd && rx_empty);
        if (bus.err_clear) begin
            tx_overflow_d  = 1'b0;
            rx_underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_overflow_q  <= 1'b0;
            rx_underflow_q <= 1'b0;
        end else begin
            tx_overflow_q  <= tx_overflow_d;
            rx_underflow_q <= rx_underflow_d;
        end
    end

    io_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_tx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (tx_push),
        .pop   (tx_pop),
        .wdata (bus.cpu_wdata),
        .rdata (tx_head),
        .full  (tx_full_i),
        .empty (tx_empty)
    );

    io_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_rx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (rx_push),
        .pop   (rx_pop),
        .wdata (rx_wdata),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign out_valid_i      = !lb_en && !tx_empty;
    assign bus.out_valid    = out_valid_i;
    assign bus.out_data     = out_valid_i ? tx_head : '0;
    assign bus.in_ready     = !lb_en && !rx_full;
    assign bus.tx_full      = tx_full_i;
    assign bus.rx_avail     = !rx_empty;
    assign bus.cpu_rdata    = rx_head;
    assign bus.tx_overflow  = tx_overflow_q;
    assign bus.rx_underflow = rx_underflow_q;

endmodule

// File: tb/tb_io_port.sv
// Bench for io_port: directed vector table, hand-written multi-cycle sequences, and
// randomized traffic checked against a queue-based reference model.
module tb_io_port;
    import io_pkg::*;

    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    io_port_if #(.WIDTH(IO_WIDTH)) bus ();
`ifdef IO_PORT_LOOPBACK_EN
    logic loopback;
`endif

    io_port #(.DEPTH(DEPTH), .WIDTH(IO_WIDTH)) dut (
        .clock    (clock),
        .reset    (reset),
`ifdef IO_PORT_LOOPBACK_EN
        .loopback (loopback),
`endif
        .bus      (bus)
    );

    typedef struct packed {
        logic  out_valid;
        byte_t out_data;
        logic  tx_full;
        logic  rx_avail;
        byte_t cpu_rdata;
        logic  in_ready;
        logic  tx_overflow;
        logic  rx_underflow;
    } outs_t;

    typedef struct packed {
        logic  cpu_wr;
        byte_t wdata;
        logic  cpu_rd;
        logic  out_ready;
        logic  in_valid;
        byte_t in_data;
        logic  err_clear;
    } ins_t;

    typedef struct {
        ins_t  i;
        outs_t e;
    } vec_t;

    int tests = 0;
    int fails = 0;
    vec_t vecs[$];
    byte_t txm[$];
    byte_t rxm[$];
    logic ovf_m, und_m;

    function automatic ins_t mk_in(logic wr, byte_t wd, logic rd, logic ordy,
                                   logic iv, byte_t id, logic clr);
        return '{wr, wd, rd, ordy, iv, id, clr};
    endfunction

    function automatic outs_t mk_out(logic ov, byte_t od, logic full, logic avail,
                                     byte_t rdat, logic irdy, logic ovf, logic und);
        return '{ov, od, full, avail, rdat, irdy, ovf, und};
    endfunction

    function automatic outs_t sample();
        return '{bus.out_valid, bus.out_data, bus.tx_full, bus.rx_avail,
                 bus.cpu_rdata, bus.in_ready, bus.tx_overflow, bus.rx_underflow};
    endfunction

    task automatic apply(input ins_t x);
        bus.cpu_wr    = x.cpu_wr;
        bus.cpu_wdata = x.wdata;
        bus.cpu_rd    = x.cpu_rd;
        bus.out_ready = x.out_ready;
        bus.in_valid  = x.in_valid;
        bus.in_data   = x.in_data;
        bus.err_clear = x.err_clear;
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input outs_t act, input outs_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_v(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: FIFOs as queues, flags as plain bits.
    task automatic model_step(input ins_t x, input logic rst);
        logic tfull, rempty, tpop, rpush, rpop, ovf_set, und_set;
        if (rst) begin
            txm.delete();
            rxm.delete();
            ovf_m = 1'b0;
            und_m = 1'b0;
        end else begin
            tfull   = (txm.size() == DEPTH);
            rempty  = (rxm.size() == 0);
            ovf_set = x.cpu_wr && tfull;
            und_set = x.cpu_rd && rempty;
            tpop    = (txm.size() > 0) && x.out_ready;
            rpush   = x.in_valid && (rxm.size() < DEPTH);
            rpop    = x.cpu_rd && !rempty;
            if (tpop) void'(txm.pop_front());
            if (x.cpu_wr && !tfull) txm.push_back(x.wdata);
            if (rpop) void'(rxm.pop_front());
            if (rpush) rxm.push_back(x.in_data);
            ovf_m = x.err_clear ? 1'b0 : (ovf_m | ovf_set);
            und_m = x.err_clear ? 1'b0 : (und_m | und_set);
        end
    endtask

    function automatic outs_t model_outs();
        return mk_out(txm.size() != 0, (txm.size() != 0) ? txm[0] : 8'h00,
                      txm.size() == DEPTH, rxm.size() != 0,
                      (rxm.size() != 0) ? rxm[0] : 8'h00,
                      rxm.size() < DEPTH, ovf_m, und_m);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ins_t  idle;
        ins_t  x;
        logic  hs, rst;
        int    sent, got, bias;
        byte_t exp_b;

        idle = mk_in(0, 8'h00, 0, 0, 0, 8'h00, 0);
`ifdef IO_PORT_LOOPBACK_EN
        loopback = 1'b0;
`endif
        apply(idle);
        reset = 1'b1;
        cycle();
        cycle();
        check("reset_state", sample(), mk_out(0, 8'h00, 0, 0, 8'h00, 1, 0, 0));
        reset = 1'b0;

        // Directed vectors: inputs held for one cycle, outputs compared after the edge.
        vecs.push_back('{mk_in(1, 8'hA5, 0, 1, 0, 8'h00, 0), mk_out(1, 8'hA5, 0, 0, 8'h00, 1, 0, 0)});
        vecs.push_back('{mk_in(0, 8'h00, 0, 1, 0, 8'h00, 0), mk_out(0, 8'h00, 0, 0, 8'h00, 1, 0, 0)});
        vecs.push_back('{mk_in(1, 8'h01, 0, 0, 0, 8'h00, 0), mk_out(1, 8'h01, 0, 0, 8'h00, 1, 0, 0)});
        vecs.push_back('{mk_in(1, 8'h02, 0, 0, 0, 8'h00, 0), mk_out(1, 8'h01, 0, 0, 8'h00, 1, 0, 0)});
        vecs.push_back('{mk_in(1, 8'h03, 0, 0, 0, 8'h00, 0), mk_out(1, 8'h01, 0, 0, 8'h00, 1, 0, 0)});
        vecs.push_back('{mk_in(1, 8'h04, 0, 0, 0, 8'h00, 0), mk_out(1, 8'h01, 1, 0, 8'h00, 1, 0, 0)});
        vecs.push_back('{mk_in(1, 8'h05, 0, 0, 0, 8'h00, 0), mk_out(1, 8'h01, 1, 0, 8'h00, 1, 1, 0)});
        vecs.push_back('{mk_in(0, 8'h00, 0, 1, 0, 8'h00, 0), mk_out(1, 8'h02, 0, 0, 8'h00, 1, 1, 0)});
        vecs.push_back('{mk_in(0, 8'h00, 0, 1, 0, 8'h00, 0), mk_out(1, 8'h03, 0, 0, 8'h00, 1, 1, 0)});
        vecs.push_back('{mk_in(0, 8'h00, 0, 1, 0, 8'h00, 0), mk_out(1, 8'h04, 0, 0, 8'h00, 1, 1, 0)});
        vecs.push_back('{mk_in(0, 8'h00, 0, 1, 0, 8'h00, 0), mk_out(0, 8'h00, 0, 0, 8'h00, 1, 1, 0)});
        vecs.push_back('{mk_in(0, 8'h00, 0, 0, 0, 8'h00, 1), mk_out(0, 8'h00, 0, 0, 8'h00, 1, 0, 0)});
        vecs.push_back('{mk_in(0, 8'h00, 0, 0, 1, 8'h3C, 0), mk_out(0, 8'h00, 0, 1, 8'h3C, 1, 0, 0)});
        vecs.push_back('{mk_in(0, 8'h00, 0, 0, 1, 8'h7E, 0), mk_out(0, 8'h00, 0, 1, 8'h3C, 1, 0, 0)});
        vecs.push_back('{mk_in(0, 8'h00, 1, 0, 0, 8'h00, 0), mk_out(0, 8'h00, 0, 1, 8'h7E, 1, 0, 0)});
        vecs.push_back('{mk_in(0, 8'h00, 1, 0, 0, 8'h00, 0), mk_out(0, 8'h00, 0, 0, 8'h00, 1, 0, 0)});
        vecs.push_back('{mk_in(0, 8'h00, 1, 0, 0, 8'h00, 0), mk_out(0, 8'h00, 0, 0, 8'h00, 1, 0, 1)});
        vecs.push_back('{mk_in(0, 8'h00, 0, 0, 0, 8'h00, 1), mk_out(0, 8'h00, 0, 0, 8'h00, 1, 0, 0)});
        vecs.push_back('{mk_in(0, 8'h00, 1, 0, 0, 8'h00, 1), mk_out(0, 8'h00, 0, 0, 8'h00, 1, 0, 0)});
        vecs.push_back('{mk_in(1, 8'h99, 0, 0, 1, 8'h77, 0), mk_out(1, 8'h99, 0, 1, 8'h77, 1, 0, 0)});
        vecs.push_back('{mk_in(0, 8'h00, 1, 1, 0, 8'h00, 0), mk_out(0, 8'h00, 0, 0, 8'h00, 1, 0, 0)});

        foreach (vecs[k]) begin
            apply(vecs[k].i);
            cycle();
            check($sformatf("vec%0d", k), sample(), vecs[k].e);
        end
        apply(idle);

        // RX backpressure: source holds six bytes, only DEPTH are accepted.
        sent = 0;
        for (int c = 0; c < 6; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'hC0 + 8'(sent);
            hs = bus.in_ready;
            cycle();
            if (hs) sent++;
        end
        check_v("rx_accepted_before_stall", sent, DEPTH);
        check_v("rx_in_ready_when_full", int'(bus.in_ready), 0);

        got = 0;
        for (int c = 0; c < 30 && got < 6; c++) begin
            bus.cpu_rd   = 1'b1;
            bus.in_valid = (sent < 6);
            bus.in_data  = 8'hC0 + 8'(sent);
            if (bus.rx_avail) begin
                exp_b = 8'hC0 + 8'(got);
                check_v($sformatf("rx_order_%0d", got), int'(bus.cpu_rdata), int'(exp_b));
                got++;
            end
            hs = bus.in_valid && bus.in_ready;
            cycle();
            if (hs) sent++;
        end
        apply(idle);
        check_v("rx_all_read", got, 6);
        check("rx_drained", sample(), mk_out(0, 8'h00, 0, 0, 8'h00, 1, 0, 0));

        // Simultaneous push and pop with two entries in TX.
        apply(mk_in(1, 8'h41, 0, 0, 0, 8'h00, 0)); cycle();
        apply(mk_in(1, 8'h42, 0, 0, 0, 8'h00, 0)); cycle();
        apply(mk_in(1, 8'h55, 0, 1, 0, 8'h00, 0)); cycle();
        check("tx_push_pop", sample(), mk_out(1, 8'h42, 0, 0, 8'h00, 1, 0, 0));
        apply(mk_in(1, 8'h66, 0, 0, 0, 8'h00, 0)); cycle();
        apply(mk_in(1, 8'h77, 0, 0, 0, 8'h00, 0)); cycle();
        check("tx_full_after_4", sample(), mk_out(1, 8'h42, 1, 0, 8'h00, 1, 0, 0));
        apply(mk_in(0, 8'h00, 0, 1, 0, 8'h00, 0)); cycle();
        check("tx_drain_55", sample(), mk_out(1, 8'h55, 0, 0, 8'h00, 1, 0, 0));
        cycle();
        check("tx_drain_66", sample(), mk_out(1, 8'h66, 0, 0, 8'h00, 1, 0, 0));
        cycle();
        check("tx_drain_77", sample(), mk_out(1, 8'h77, 0, 0, 8'h00, 1, 0, 0));
        cycle();
        check("tx_drain_empty", sample(), mk_out(0, 8'h00, 0, 0, 8'h00, 1, 0, 0));

        // Reset in the middle of traffic with flags set.
        for (int c = 0; c < 5; c++) begin
            apply(mk_in(1, 8'(8'h20 + c), 1, 0, 1, 8'hE1, 0));
            cycle();
        end
        check("pre_reset_busy", sample(), mk_out(1, 8'h20, 1, 1, 8'hE1, 1, 1, 1));
        apply(mk_in(1, 8'hF0, 1, 1, 1, 8'hF1, 0));
        reset = 1'b1;
        cycle();
        check("reset_mid_stream", sample(), mk_out(0, 8'h00, 0, 0, 8'h00, 1, 0, 0));
        reset = 1'b0;
        apply(idle);
        cycle();
        check("post_reset_idle", sample(), mk_out(0, 8'h00, 0, 0, 8'h00, 1, 0, 0));

        // Randomized traffic against the queue model; bias alternates fill/drain phases.
        txm.delete();
        rxm.delete();
        ovf_m = 1'b0;
        und_m = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            bias = (n / 200) % 2;
            x.cpu_wr    = ($urandom_range(0, 9) < (bias ? 7 : 3));
            x.wdata     = byte_t'($urandom);
            x.cpu_rd    = ($urandom_range(0, 9) < (bias ? 3 : 7));
            x.out_ready = ($urandom_range(0, 9) < (bias ? 3 : 7));
            x.in_valid  = ($urandom_range(0, 9) < (bias ? 7 : 3));
            x.in_data   = byte_t'($urandom);
            x.err_clear = ($urandom_range(0, 19) == 0);
            rst         = ($urandom_range(0, 149) == 0);
            apply(x);
            reset = rst;
            model_step(x, rst);
            cycle();
            check($sformatf("random_%0d", n), sample(), model_outs());
        end
        reset = 1'b0;
        apply(idle);

`ifdef IO_PORT_LOOPBACK_EN
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        loopback = 1'b1;
        apply(mk_in(1, 8'h11, 0, 1, 1, 8'hEE, 0)); cycle();
        check("lb_write_11", sample(), mk_out(0, 8'h00, 0, 0, 8'h00, 0, 0, 0));
        apply(mk_in(1, 8'h22, 0, 1, 1, 8'hEE, 0)); cycle();
        check("lb_move_11", sample(), mk_out(0, 8'h00, 0, 1, 8'h11, 0, 0, 0));
        apply(mk_in(0, 8'h00, 1, 1, 1, 8'hEE, 0)); cycle();
        check("lb_read_22", sample(), mk_out(0, 8'h00, 0, 1, 8'h22, 0, 0, 0));
        apply(mk_in(0, 8'h00, 1, 1, 1, 8'hEE, 0)); cycle();
        check("lb_empty", sample(), mk_out(0, 8'h00, 0, 0, 8'h00, 0, 0, 0));
        loopback = 1'b0;
        apply(idle);
        cycle();
        check("lb_off", sample(), mk_out(0, 8'h00, 0, 0, 8'h00, 1, 0, 0));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
